// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES block cipher, one round per clock.
// NK selects AES-128/192/256 (4/6/8 key words); NR = NK+6 rounds.
// Round keys are requested on rk_idx and returned combinationally on rk_data.
// Optional decryption (standard inverse cipher, forward key schedule) is
// compiled in when AES_CIPHER_DEC_EN is defined; default build is encrypt-only.

module aes_cipher_core #(
   parameter int NK = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
`ifdef AES_CIPHER_DEC_EN
   input  logic         decrypt,
`endif
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam int         NR     = NK + 6;
   localparam logic [3:0] NR_IDX = 4'(NR);

   generate
      if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
         $error("aes_cipher_core: NK must be 4, 6 or 8");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_t;

   // ---------------- GF(2^8) helpers and transforms ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = gf_mul(a, a);
      acc = sq;
      for (int i = 0; i < 6; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box built from inverse plus affine map rather than a 256-entry table.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] t;
      t = gf_inv(a);
      return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   // Byte 4c+r holds row r, column c; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return o;
   endfunction

`ifdef AES_CIPHER_DEC_EN
   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] =
            {gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9),
             gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13),
             gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11),
             gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14)};
      end
      return o;
   endfunction
`endif

   // ---------------- state ----------------
   state_t       state_q, state_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] stm_q, stm_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
`ifdef AES_CIPHER_DEC_EN
   logic         mode_q, mode_d;   // 1 = current block is a decryption
`endif

   // ---------------- round datapath ----------------
   logic [127:0] sb_sr;
   logic [127:0] enc_round;
   logic [127:0] enc_final;

   assign sb_sr     = shift_rows(sub_bytes(stm_q));
   assign enc_round = mix_columns(sb_sr) ^ rk_data;
   assign enc_final = sb_sr ^ rk_data;

`ifdef AES_CIPHER_DEC_EN
   logic [127:0] dec_step;
   logic [127:0] dec_round;

   assign dec_step  = inv_sub_bytes(inv_shift_rows(stm_q)) ^ rk_data;
   assign dec_round = inv_mix_columns(dec_step);
`endif

   // Next-state, round counter and state-matrix update; handshake flags follow the next state.
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      stm_d   = stm_q;
`ifdef AES_CIPHER_DEC_EN
      mode_d  = mode_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               stm_d   = in_data ^ rk_data;
               rnd_d   = 4'd1;
               state_d = ROUND;
`ifdef AES_CIPHER_DEC_EN
               mode_d  = decrypt;
`endif
            end
         end
         ROUND: begin
`ifdef AES_CIPHER_DEC_EN
            stm_d = mode_q ? dec_round : enc_round;
`else
            stm_d = enc_round;
`endif
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == NR_IDX - 4'd1) state_d = FINAL;
         end
         FINAL: begin
`ifdef AES_CIPHER_DEC_EN
            stm_d = mode_q ? dec_step : enc_final;
`else
            stm_d = enc_final;
`endif
            state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == HOLD);
   end

   // All state flops; reset discards any block in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rnd_q       <= 4'd0;
         stm_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef AES_CIPHER_DEC_EN
         mode_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rnd_q       <= rnd_d;
         stm_q       <= stm_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef AES_CIPHER_DEC_EN
         mode_q      <= mode_d;
`endif
      end
   end

   // Round-key index decoded from the state register. In IDLE the key for the
   // block about to be accepted is needed, so its direction comes from the
   // decrypt input that will be latched on that edge.
   always_comb begin
      rk_idx = 4'd0;
      case (state_q)
`ifdef AES_CIPHER_DEC_EN
         IDLE:    rk_idx = decrypt ? NR_IDX : 4'd0;
         ROUND:   rk_idx = mode_q ? (NR_IDX - rnd_q) : rnd_q;
         FINAL:   rk_idx = mode_q ? 4'd0 : NR_IDX;
`else
         ROUND:   rk_idx = rnd_q;
         FINAL:   rk_idx = NR_IDX;
`endif
         default: rk_idx = 4'd0;
      endcase
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = stm_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// tb_aes_cipher_core: three cores (NK=4/6/8) sharing in_data/out_ready/reset,
// each with its own key-schedule table feeding rk_data from rk_idx.
// Expected blocks are queued at acceptance and checked when out_valid rises.

module tb_aes_cipher_core;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEYB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PTB    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CTB    = 128'h3925841d02dc09fbdc118597196a0b32;

   typedef struct {
      logic [127:0] data;
      int           rise;
   } exp_t;

   logic         clk;
   logic         reset;
   logic         out_ready;
   logic [127:0] in_data;
   logic         in_valid_v  [3];
   logic         in_ready_v  [3];
   logic [3:0]   rk_idx_v    [3];
   logic [127:0] rk_data_v   [3];
   logic         out_valid_v [3];
   logic [127:0] out_data_v  [3];
   logic [127:0] rk_tab [3][16];

   exp_t         exp_q [3][$];
   exp_t         cur   [3];
   logic         ov_prev [3];
   logic         hs_last [3];
   logic [3:0]   rk_hist [256];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         aes_cipher_core #(.NK(4 + 2*gi)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid_v[gi]),
            .in_ready  (in_ready_v[gi]),
            .in_data   (in_data),
            .rk_idx    (rk_idx_v[gi]),
            .rk_data   (rk_data_v[gi]),
            .out_valid (out_valid_v[gi]),
            .out_ready (out_ready),
            .out_data  (out_data_v[gi])
         );
         assign rk_data_v[gi] = rk_tab[gi][rk_idx_v[gi]];
      end
   endgenerate

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // FIPS-197 key expansion into the round-key table of one instance.
   task automatic load_key(input int inst, input int nk, input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         if (r <= nr) rk_tab[inst][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else         rk_tab[inst][r] = '0;
      end
   endtask

   // Present a block until accepted; optionally queue its expected result.
   task automatic send(input int inst, input logic [127:0] data, input logic [127:0] exp,
                       input bit push, output int acc);
      bit   done;
      exp_t e;
      done = 1'b0;
      acc  = -1;
      @(negedge clk);
      in_data          = data;
      in_valid_v[inst] = 1'b1;
      for (int k = 0; k < 100 && !done; k++) begin
         if (in_ready_v[inst]) begin
            @(posedge clk);
            #1;
            acc  = cyc;
            done = 1'b1;
            if (push) begin
               e.data = exp;
               e.rise = cyc + 10 + 2*inst;
               exp_q[inst].push_back(e);
            end
         end else begin
            @(negedge clk);
         end
      end
      check($sformatf("accept_nk%0d", 4 + 2*inst), done, 1);
      @(negedge clk);
      in_valid_v[inst] = 1'b0;
   endtask

   task automatic drain(input int max);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < max && !ok; k++) begin
         @(negedge clk);
         ok = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0) &&
              !out_valid_v[0] && !out_valid_v[1] && !out_valid_v[2];
      end
      check("drain", ok, 1);
   endtask

   // Handshake seen on the last edge, per instance.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) hs_last[i] <= !reset && out_valid_v[i] && out_ready;
   end

   // Round-key index history of the NK=8 core, indexed by cycle.
   always @(negedge clk) rk_hist[cyc & 255] <= rk_idx_v[2];

   // Output monitor: pop and compare on each rising out_valid, then watch the hold.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            ov_prev[i] <= 1'b0;
         end else begin
            if (hs_last[i]) check($sformatf("valid_drop_nk%0d", 4 + 2*i), out_valid_v[i], 0);
            if (out_valid_v[i]) begin
               if (!ov_prev[i]) begin
                  if (exp_q[i].size() == 0) begin
                     check($sformatf("unexpected_nk%0d", 4 + 2*i), exp_q[i].size(), 1);
                  end else begin
                     e = exp_q[i].pop_front();
                     cur[i] <= e;
                     check($sformatf("data_nk%0d", 4 + 2*i), out_data_v[i], e.data);
                     check($sformatf("latency_nk%0d", 4 + 2*i), cyc, e.rise);
                  end
               end else begin
                  check($sformatf("hold_nk%0d", 4 + 2*i), out_data_v[i], cur[i].data);
               end
               check($sformatf("busy_in_ready_nk%0d", 4 + 2*i), in_ready_v[i], 0);
            end
            ov_prev[i] <= out_valid_v[i];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         acc;
      int         acc2;
      int         hs;
      bit         got;
      logic [3:0] want;

      reset     = 1'b1;
      out_ready = 1'b0;
      in_data   = '0;
      for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;
      load_key(0, 4, KEY128);
      load_key(1, 6, KEY192);
      load_key(2, 8, KEY256);

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_in_ready_nk%0d", 4 + 2*i), in_ready_v[i], 1);
         check($sformatf("rst_out_valid_nk%0d", 4 + 2*i), out_valid_v[i], 0);
         check($sformatf("rst_out_data_nk%0d", 4 + 2*i), out_data_v[i], '0);
         check($sformatf("rst_rk_idx_nk%0d", 4 + 2*i), rk_idx_v[i], 0);
      end
      reset     = 1'b0;
      out_ready = 1'b1;

      // FIPS-197 vectors for all three key lengths.
      send(0, PT, CT128, 1, acc);
      send(1, PT, CT192, 1, acc);
      send(2, PT, CT256, 1, acc2);
      drain(60);

      // Round-key index sequence for NK=8, from the cycle before acceptance.
      for (int k = -1; k <= 14; k++) begin
         if (k < 0 || k == 14) want = 4'd0;
         else if (k == 13)     want = 4'd14;
         else                  want = 4'(k + 1);
         check($sformatf("rk_idx_nk8_step%0d", k + 1), rk_hist[(acc2 + k) & 255], want);
      end

      // Reset in round 5 with in_valid still held.
      send(0, PT, '0, 0, acc);
      in_valid_v[0] = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", out_valid_v[0], 0);
      check("midrst_in_ready", in_ready_v[0], 1);
      check("midrst_out_data", out_data_v[0], '0);
      reset         = 1'b0;
      in_valid_v[0] = 1'b0;
      send(0, PT, CT128, 1, acc);
      drain(40);

      // Backpressure: result held for 20 cycles, then one handshake.
      load_key(0, 4, KEYB);
      out_ready = 1'b0;
      send(0, PTB, CTB, 1, acc);
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         got = out_valid_v[0];
      end
      check("bp_valid_seen", got, 1);
      repeat (20) @(negedge clk);
      check("bp_in_ready_low", in_ready_v[0], 0);
      in_data       = PTB;
      in_valid_v[0] = 1'b1;
      out_ready     = 1'b1;
      @(posedge clk);
      #1;
      hs = cyc;
      send(0, PTB, CTB, 1, acc);
      check("reaccept_cycle", acc, hs + 1);
      drain(40);

      for (int i = 0; i < 3; i++)
         check($sformatf("queue_empty_nk%0d", 4 + 2*i), exp_q[i].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
